updown_count_core: RTL

Counting stage directly downstream of the clock divider. It samples the divider's slow square wave `sclk` in the `clk` domain and turns each rising edge into a one-cycle count tick. On each tick it advances a `WIDTH`-bit up/down counter under synchronized switch control. It drives the count, a terminal-count pulse and an optional seven-segment digit for the board display.

---
 rtl/updown_count_core.sv | 134 +++++++++++++
 1 files changed

// File: rtl/updown_count_core.sv
// Up/down counter stepped by rising edges of the divider output, with synchronized switch
// controls and an optional seven-segment digit (built when UPDOWN_SEG7_EN is defined).
module updown_count_core #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WRAP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             en_sw,
  input  logic             up_sw,
  input  logic             load_sw,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir_led,
  output logic [6:0]       seg
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  // Control bits per stage: {load, up, en}
  logic [SYNC_STAGES-1:0][2:0]       ctl_sync_q, ctl_sync_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] val_sync_q, val_sync_d;
  logic                              sclk_d_q;
  logic [WIDTH-1:0]                  count_q, count_d;
  logic                              tc_q, tc_d;
  logic                              en_s, up_s, load_s, tick;
  logic [WIDTH-1:0]                  val_s;

  always_comb begin
    ctl_sync_d    = ctl_sync_q;
    val_sync_d    = val_sync_q;
    ctl_sync_d[0] = {load_sw, up_sw, en_sw};
    val_sync_d[0] = load_val;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ctl_sync_d[i] = ctl_sync_q[i-1];
      val_sync_d[i] = val_sync_q[i-1];
    end
  end

  assign en_s   = ctl_sync_q[SYNC_STAGES-1][0];
  assign up_s   = ctl_sync_q[SYNC_STAGES-1][1];
  assign load_s = ctl_sync_q[SYNC_STAGES-1][2];
  assign val_s  = val_sync_q[SYNC_STAGES-1];
  assign tick   = sclk & ~sclk_d_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (tick) begin
      if (load_s) begin
        count_d = val_s;
      end else if (en_s && up_s) begin
        if (count_q == CntMax) begin
          count_d = (WRAP != 0) ? '0 : CntMax;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else if (en_s) begin
        if (count_q == '0) begin
          count_d = (WRAP != 0) ? CntMax : '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // sclk_d resets high so an sclk already high at reset release is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_sync_q <= '0;
      val_sync_q <= '0;
      sclk_d_q   <= 1'b1;
      count_q    <= '0;
      tc_q       <= 1'b0;
    end else begin
      ctl_sync_q <= ctl_sync_d;
      val_sync_q <= val_sync_d;
      sclk_d_q   <= sclk;
      count_q    <= count_d;
      tc_q       <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign dir_led = up_s;

`ifdef UPDOWN_SEG7_EN
  localparam int unsigned NibW = (WIDTH < 4) ? WIDTH : 4;

  logic [3:0] nib;
  logic [6:0] seg_q, seg_d;

  assign nib = 4'(count_q[NibW-1:0]);

  always_comb begin
    seg_d = 7'b1111111;
    case (nib)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) seg_q <= 7'b1000000;
    else       seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = 7'b1111111;
`endif

endmodule
